// File: rtl/signed_max_window.sv
// Windowed signed maximum: collects WINDOW samples, then holds the largest value
// and its first position until the result is taken downstream.
//
// state | meaning
// ACCUM | accepting samples, folding each one into the running max
// EMIT  | holding a result on O/O_IDX with O_VALID high
module signed_max_window #(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 4
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             CLR,
  input  logic [WIDTH-1:0] I,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic [WIDTH-1:0] O,
  output logic [7:0]       O_IDX,
  output logic             O_VALID,
  input  logic             O_READY
);

  localparam int CNT_W = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] max_q;
  logic [7:0]       idx_q;

  logic             first;
  logic             gt;
  logic             take;
  logic [WIDTH-1:0] max_nxt;
  logic [7:0]       idx_nxt;

  // Strictly-greater compare keeps the earliest sample on ties.
  always_comb begin
    first   = (cnt == '0);
    gt      = $signed(I) > $signed(max_q);
    take    = first || gt;
    max_nxt = take ? I : max_q;
    idx_nxt = first ? 8'd0 : (gt ? 8'(cnt) : idx_q);
  end

  assign I_READY = (state == ACCUM);

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state   <= ACCUM;
      cnt     <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      O       <= '0;
      O_IDX   <= '0;
      O_VALID <= 1'b0;
    end else if (CLR) begin
      state   <= ACCUM;
      cnt     <= '0;
      O_VALID <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (I_VALID) begin
            max_q <= max_nxt;
            idx_q <= idx_nxt;
            // Last sample of the window goes straight into the output registers.
            if (cnt == CNT_LAST) begin
              O       <= max_nxt;
              O_IDX   <= idx_nxt;
              O_VALID <= 1'b1;
              cnt     <= '0;
              state   <= EMIT;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        EMIT: begin
          if (O_READY) begin
            state   <= ACCUM;
            O_VALID <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_max_window.sv
// Bench for signed_max_window: directed WIDTH=8/WINDOW=4 steps plus a
// WIDTH=4/WINDOW=2 random stream, both checked against a queued reference.
module tb_signed_max_window;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       clr_a, iv_a, ir_a, ov_a, or_a;
  logic [7:0] i_a, o_a, idx_a;
  logic       clr_b, iv_b, ir_b, ov_b, or_b;
  logic [3:0] i_b, o_b;
  logic [7:0] idx_b;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] q_a[$];
  logic [11:0] q_b[$];
  logic [7:0]  last_o_a, last_idx_a;

  signed_max_window #(.WIDTH(8), .WINDOW(4)) dut_a (
    .CLK(clk), .ASYNCRESETN(rst_n), .CLR(clr_a),
    .I(i_a), .I_VALID(iv_a), .I_READY(ir_a),
    .O(o_a), .O_IDX(idx_a), .O_VALID(ov_a), .O_READY(or_a)
  );

  signed_max_window #(.WIDTH(4), .WINDOW(2)) dut_b (
    .CLK(clk), .ASYNCRESETN(rst_n), .CLR(clr_b),
    .I(i_b), .I_VALID(iv_b), .I_READY(ir_b),
    .O(o_b), .O_IDX(idx_b), .O_VALID(ov_b), .O_READY(or_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int s0, input int s1, input int s2, input int s3);
    logic signed [7:0] s[4];
    logic signed [7:0] m;
    int idx;
    s[0] = 8'(s0); s[1] = 8'(s1); s[2] = 8'(s2); s[3] = 8'(s3);
    m = s[0];
    idx = 0;
    for (int k = 1; k < 4; k++) begin
      if (s[k] > m) begin
        m = s[k];
        idx = k;
      end
    end
    q_a.push_back({8'(idx), m});
  endtask

  // Leaves I_VALID high so consecutive calls model a continuous stream.
  task automatic send_a(input int v);
    int g = 0;
    i_a  = 8'(v);
    iv_a = 1'b1;
    while (!ir_a && g < 50) begin
      step();
      g++;
    end
    check("send_a_ready", ir_a, 1);
    step();
  endtask

  task automatic expect_a(input string tag);
    int g = 0;
    logic [15:0] e;
    while (!ov_a && g < 50) begin
      step();
      g++;
    end
    check({tag, "_valid"}, ov_a, 1);
    e = (q_a.size() != 0) ? q_a.pop_front() : 16'hxxxx;
    check({tag, "_o"}, o_a, e[7:0]);
    check({tag, "_idx"}, idx_a, e[15:8]);
    last_o_a   = e[7:0];
    last_idx_a = e[15:8];
  endtask

  task automatic handshake_a(input string tag);
    iv_a = 1'b0;
    or_a = 1'b1;
    step();
    or_a = 1'b0;
    check({tag, "_hs_valid"}, ov_a, 0);
    check({tag, "_hs_ready"}, ir_a, 1);
    check({tag, "_hs_o_kept"}, o_a, last_o_a);
    check({tag, "_hs_idx_kept"}, idx_a, last_idx_a);
  endtask

  initial begin
    int wins_in, wins_out, cyc, nb;
    logic acc, emt;
    logic [3:0] bs[2];
    logic [3:0] m_b;
    logic [7:0] ix_b;
    logic [11:0] e_b;

    rst_n = 1'b0;
    clr_a = 1'b0; iv_a = 1'b0; i_a = '0; or_a = 1'b0;
    clr_b = 1'b0; iv_b = 1'b0; i_b = '0; or_b = 1'b0;
    #3;
    check("rst_ready_a", ir_a, 1);
    check("rst_valid_a", ov_a, 0);
    check("rst_o_a", o_a, 0);
    check("rst_idx_a", idx_a, 0);
    check("rst_valid_b", ov_b, 0);
    check("rst_o_b", o_b, 0);
    #19 rst_n = 1'b1;

    // Basic window, I_VALID held high, one-cycle latency
    push_a(3, -5, 7, 2);
    send_a(3); send_a(-5); send_a(7);
    check("w1_no_early_valid", ov_a, 0);
    send_a(2);
    check("w1_ready_low", ir_a, 0);
    check("w1_valid_next", ov_a, 1);
    expect_a("w1");
    i_a = 8'd99;
    step(); step();
    check("w1_emit_ignores_in_o", o_a, 7);
    check("w1_emit_ignores_in_idx", idx_a, 2);
    check("w1_emit_valid", ov_a, 1);
    handshake_a("w1");

    // Extremes and tie
    push_a(-128, -1, -1, -128);
    send_a(-128); send_a(-1); send_a(-1); send_a(-128);
    expect_a("w2");
    handshake_a("w2");

    // Backpressure for 5 cycles
    push_a(127, -128, 0, 127);
    send_a(127); send_a(-128); send_a(0); send_a(127);
    expect_a("w3");
    iv_a = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("w3_hold_valid", ov_a, 1);
      check("w3_hold_o", o_a, 8'h7f);
      check("w3_hold_ready", ir_a, 0);
    end
    handshake_a("w3");

    // CLR mid-window wins over I_VALID and O_READY
    send_a(50); send_a(60);
    i_a = 8'd100; clr_a = 1'b1; or_a = 1'b1;
    step();
    clr_a = 1'b0; or_a = 1'b0; iv_a = 1'b0;
    check("clr_valid", ov_a, 0);
    check("clr_ready", ir_a, 1);
    push_a(1, 2, 3, 4);
    send_a(1); send_a(2);
    check("clr_no_partial_2", ov_a, 0);
    send_a(3);
    check("clr_no_partial_3", ov_a, 0);
    send_a(4);
    expect_a("w4");
    handshake_a("w4");

    // Asynchronous reset while in EMIT
    push_a(5, 6, -7, 8);
    send_a(5); send_a(6); send_a(-7); send_a(8);
    expect_a("w5");
    iv_a = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", ov_a, 0);
    check("arst_o", o_a, 0);
    check("arst_idx", idx_a, 0);
    check("arst_ready", ir_a, 1);
    #1 rst_n = 1'b1;

    // Reset mid-window discards the partial window
    send_a(100); send_a(101);
    iv_a = 1'b0;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    push_a(-3, -2, -9, -2);
    send_a(-3); send_a(-2); send_a(-9);
    check("w6_no_early_valid", ov_a, 0);
    send_a(-2);
    expect_a("w6");
    handshake_a("w6");
    check("sb_a_empty", q_a.size(), 0);

    // Random stream on WIDTH=4/WINDOW=2; first 256 windows cover every pair
    wins_in = 0; wins_out = 0; cyc = 0; nb = 0;
    iv_b = 1'b0;
    while (wins_out < 1000 && cyc < 60000) begin
      if (!iv_b && wins_in < 1000 && $urandom_range(3) != 0) begin
        iv_b = 1'b1;
        if (wins_in < 256) i_b = (nb == 0) ? 4'(wins_in >> 4) : 4'(wins_in);
        else               i_b = 4'($urandom);
      end
      or_b = 1'($urandom_range(1));
      acc = iv_b && ir_b;
      emt = ov_b && or_b;
      if (emt) begin
        e_b = (q_b.size() != 0) ? q_b.pop_front() : 12'hxxx;
        check("rand_o", o_b, e_b[3:0]);
        check("rand_idx", idx_b, e_b[11:4]);
        wins_out++;
      end
      if (acc) begin
        bs[nb] = i_b;
        nb++;
        if (nb == 2) begin
          m_b = bs[0];
          ix_b = 8'd0;
          if ($signed(bs[1]) > $signed(m_b)) begin
            m_b = bs[1];
            ix_b = 8'd1;
          end
          q_b.push_back({ix_b, m_b});
          nb = 0;
          wins_in++;
        end
      end
      step();
      cyc++;
      if (acc) iv_b = 1'b0;
    end
    check("rand_windows_out", wins_out, 1000);
    check("sb_b_empty", q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/signed_max_window.md
SIGNED_MAX_WINDOW -- requirements
Module: signed_max_window

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the sample width in bits as two's-complement signed; legal range 2..32.
REQ-002 Parameter WINDOW, default 4, SHALL set the number of accepted samples per window; legal range 2..256.
REQ-003 Port CLK, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port ASYNCRESETN, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-005 Port CLR, input, 1 bit, SHALL be a synchronous window abort.
REQ-006 Port I, input, WIDTH bits, signed, SHALL carry the sample.
REQ-007 Port I_VALID, input, 1 bit, SHALL indicate that I holds a sample.
REQ-008 Port I_READY, output, 1 bit, SHALL indicate that the block accepts a sample this cycle.
REQ-009 Port O, output, WIDTH bits, signed, SHALL carry the window maximum.
REQ-010 Port O_IDX, output, 8 bits, SHALL carry the zero-based position of the maximum within its window.
REQ-011 Port O_VALID, output, 1 bit, SHALL indicate that O and O_IDX hold a result.
REQ-012 Port O_READY, input, 1 bit, SHALL indicate that downstream consumes the result.

Function
REQ-013 The block SHALL be a two-state FSM: ACCUM (collecting samples) and EMIT (holding a result).
REQ-014 A sample SHALL be accepted only in a cycle where I_VALID=1 and I_READY=1.
REQ-015 I_READY SHALL equal 1 in ACCUM and 0 in EMIT, decoded from state with no combinational path from I_VALID.
REQ-016 A sample counter CNT (0..WINDOW-1) SHALL increment on each accepted sample.
REQ-017 The first accepted sample of a window (CNT=0) SHALL load the max register and set the index register to 0 unconditionally.
REQ-018 A later accepted sample SHALL replace the max only when it is signed strictly greater than the current max; the index register then loads CNT.
REQ-019 On ties, the earliest sample SHALL be retained.
REQ-020 The comparison SHALL be full WIDTH-bit signed with no overflow; -2^(WIDTH-1) SHALL be smallest and 2^(WIDTH-1)-1 largest.
REQ-021 When the WINDOW-th sample is accepted (CNT=WINDOW-1), the block SHALL move to EMIT on that edge and reset CNT to 0.
REQ-022 In that same edge, the final compare, including the last sample, SHALL be folded into O and O_IDX.
REQ-023 O_VALID SHALL go high the next cycle, giving a latency of 1 clock from the last accept to O_VALID.
REQ-024 O, O_IDX and O_VALID SHALL be driven directly from registers.
REQ-025 In EMIT, O, O_IDX and O_VALID SHALL stay stable until a cycle with O_READY=1.
REQ-026 On that O_READY=1 edge the FSM SHALL return to ACCUM and clear O_VALID.
REQ-027 O and O_IDX SHALL keep their last values after O_VALID falls.
REQ-028 The earliest acceptance of a new sample after an EMIT handshake SHALL be the cycle after that handshake, so the sustained rate is WINDOW samples per WINDOW+1 cycles.
REQ-029 When CLR=1 the block SHALL go to ACCUM, set CNT=0 and O_VALID=0, and ignore I_VALID and O_READY for that cycle; CLR SHALL take priority over every other event.
REQ-030 After CLR, the window SHALL restart from its first sample, and no partial-window result SHALL ever be emitted.
REQ-031 I_VALID=1 in EMIT SHALL have no effect, and the sample SHALL remain the upstream's responsibility.
REQ-032 O_READY in ACCUM SHALL be ignored.

Reset
REQ-033 Asserting ASYNCRESETN=0 SHALL, without a clock, set state to ACCUM, CNT=0, O=0, O_IDX=0 and O_VALID=0, with I_READY=1 once reset is released.
REQ-034 Reset asserted mid-window or in EMIT SHALL discard all partial and held results.
REQ-035 Deassertion SHALL be synchronised externally, and the first accept SHALL be allowed on the first clock edge after release.

Verification (WIDTH=8, WINDOW=4 unless noted)
REQ-036 Samples 3,-5,7,2 with I_VALID held high -> I_READY low the cycle after the 4th accept, O=7, O_IDX=2, O_VALID=1 one cycle after the 4th accept.
REQ-037 Samples -128,-1,-1,-128 -> O=-1, O_IDX=1 (tie keeps earliest).
REQ-038 Samples 127,-128,0,127 with O_READY held 0 for 5 cycles -> O_VALID and O stable for all 5 cycles, I_READY=0 throughout.
REQ-039 Then O_READY=1 -> O_VALID=0 and I_READY=1 the next cycle.
REQ-040 After 2 samples assert CLR, then feed 1,2,3,4 -> O=4, O_IDX=3, and no earlier O_VALID pulse.
REQ-041 Drive ASYNCRESETN=0 between clock edges while in EMIT -> O_VALID=0 and O=0 immediately.
REQ-042 After release, the next four samples form a fresh window.
REQ-043 With WIDTH=4, WINDOW=2, run an exhaustive random stream of 1000 windows with random I_VALID and O_READY gaps -> every result matches a reference model's signed max and first index, with no accepted sample lost or duplicated.
